// File: rtl/apb3_initiator.sv
// APB3 initiator: single-word command/response front end driving one APB3 transfer at a time.
// Hung slaves are aborted after a programmable number of wait states.
module apb3_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic [15:0] wait_nxt;

    assign wait_nxt = wait_cnt + 16'd1;

    // Handshake and bus strobes decode from state alone, so reset drops them at once.
    assign cmd_ready = (state == IDLE);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE   <= cmd_write;
                        PADDR    <= cmd_addr;
                        PWDATA   <= cmd_wdata;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? 32'd0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_nxt;
                        if (TO != 16'd0 && wait_nxt == TO) begin
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                            state       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_initiator.sv
// Directed bench for apb3_initiator: write, wait-state read, slave error,
// timeout, completion at the timeout edge, backpressure and async reset.
module tb_apb3_initiator;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    apb3_initiator #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command for one edge; returns just after the accept edge.
    task automatic issue(input logic w, input logic [7:0] a,
                         input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("consume_valid", rsp_valid, 0);
        chk("consume_ready", cmd_ready, 1);
    endtask

    initial begin
        PRESETN = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; PRDATA = 0; PREADY = 1; PSLVERR = 0;
        #12;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_rdata[29:0], rsp_err, rsp_timeout}, 0);
        PRESETN = 1'b1;
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);

        // Zero-wait write
        PREADY = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b1, 8'h04, 32'h0000_05DC);
        rsp_ready = 1'b0;
        chk("wr_setup_psel", PSEL, 1);
        chk("wr_setup_pen", PENABLE, 0);
        chk("wr_pwrite", PWRITE, 1);
        chk("wr_paddr", PADDR, 32'h04);
        chk("wr_pwdata", PWDATA, 32'h5DC);
        chk("wr_cmd_ready", cmd_ready, 0);
        tick();
        chk("wr_acc_psel", PSEL, 1);
        chk("wr_acc_pen", PENABLE, 1);
        tick();
        chk("wr_done_psel", PSEL, 0);
        chk("wr_done_pen", PENABLE, 0);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_to", rsp_timeout, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        consume();

        // Read, 3 wait states
        PREADY = 1'b0;
        PRDATA = 32'h0BAD_0BAD;
        issue(1'b0, 8'h00, 32'hFFFF_FFFF);
        chk("rd_pwrite", PWRITE, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_wait_pen", PENABLE, 1);
            chk("rd_wait_paddr", PADDR, 0);
            chk("rd_wait_rsp", rsp_valid, 0);
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'hDEAD_BEEF;
            end
        end
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_pen_off", PENABLE, 0);
        chk("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_err", rsp_err, 0);
        chk("rd_to", rsp_timeout, 0);
        PRDATA = 32'h0;
        consume();

        // Read with slave error
        PREADY = 1'b1;
        PSLVERR = 1'b1;
        PRDATA = 32'h1234_5678;
        issue(1'b0, 8'h04, 32'h0);
        tick();
        tick();
        PSLVERR = 1'b0;
        chk("se_rsp_valid", rsp_valid, 1);
        chk("se_err", rsp_err, 1);
        chk("se_to", rsp_timeout, 0);
        chk("se_rdata", rsp_rdata, 32'h1234_5678);
        consume();

        // Timeout with PREADY stuck low; PSLVERR high while waiting is ignored
        PREADY = 1'b0;
        PSLVERR = 1'b1;
        PRDATA = 32'hCAFE_F00D;
        issue(1'b0, 8'h08, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_pen", PENABLE, 1);
            chk("to_psel", PSEL, 1);
        end
        tick();
        chk("to_psel_off", PSEL, 0);
        chk("to_pen_off", PENABLE, 0);
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_err", rsp_err, 1);
        chk("to_flag", rsp_timeout, 1);
        chk("to_rdata", rsp_rdata, 0);
        PSLVERR = 1'b0;

        // Backpressure with a pending command
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h00;
        cmd_wdata = 32'h00A5_5A00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", PSEL, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 34'h3);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_ready_back", cmd_ready, 1);
        chk("bp_psel_idle", PSEL, 0);
        tick();
        cmd_valid = 1'b0;
        chk("bp_setup_psel", PSEL, 1);
        chk("bp_setup_pen", PENABLE, 0);
        chk("bp_paddr", PADDR, 32'h00);
        chk("bp_pwdata", PWDATA, 32'h00A5_5A00);
        PREADY = 1'b1;
        tick();
        tick();
        chk("bp_rsp_valid2", rsp_valid, 1);
        chk("bp_err2", rsp_err, 0);
        consume();

        // Completion on the edge the counter would reach the limit
        PREADY = 1'b0;
        PRDATA = 32'h5555_AAAA;
        issue(1'b0, 8'h04, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("edge_pen", PENABLE, 1);
        end
        PREADY = 1'b1;
        tick();
        chk("edge_rsp_valid", rsp_valid, 1);
        chk("edge_to", rsp_timeout, 0);
        chk("edge_err", rsp_err, 0);
        chk("edge_rdata", rsp_rdata, 32'h5555_AAAA);
        consume();

        // Async reset during ACCESS
        PREADY = 1'b0;
        issue(1'b1, 8'h04, 32'h1);
        tick();
        chk("ar_pen_pre", PENABLE, 1);
        #2;
        PRESETN = 1'b0;
        #1;
        chk("ar_psel", PSEL, 0);
        chk("ar_pen", PENABLE, 0);
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_paddr", PADDR, 0);
        #10;
        PRESETN = 1'b1;
        tick();
        chk("ar_cmd_ready", cmd_ready, 1);
        chk("ar_no_rsp", rsp_valid, 0);
        PREADY = 1'b1;
        issue(1'b1, 8'h00, 32'h0000_0077);
        chk("ar_setup_psel", PSEL, 1);
        chk("ar_pwdata", PWDATA, 32'h77);
        tick();
        tick();
        chk("ar_rsp_valid2", rsp_valid, 1);
        chk("ar_err2", rsp_err, 0);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
